reg_file_sb: RTL
================

# reg_file_sb

Parametrised architectural register file with per-register scoreboard for the pipelined core. Provides READ_PORTS combinational read ports, one write port, optional write-to-read bypass, and a busy bit per register for RAW hazard detection between issue and writeback. Sits in decode: issue marks destinations pending, writeback writes data and clears them. A debug read port replaces the fixed a0 tap.

## Interface
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register width
- READ_PORTS, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = no forwarding

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  READ_PORTS*ADDRESS_WIDTH  read addresses, port i at bits [i*AW +: AW]
- rd  out  READ_PORTS*DATA_WIDTH  read data, port i at [i*DW +: DW]
- rd_ready  out  READ_PORTS  1 = value on rd[i] is final (no pending producer)
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDRESS_WIDTH  destination being issued
- we  in  1  writeback enable
- wa  in  ADDRESS_WIDTH  writeback address
- wd  in  DATA_WIDTH  writeback data
- flush  in  1  clear all busy bits (pipeline squash)
- dbg_addr  in  ADDRESS_WIDTH  debug read address
- dbg_data  out  DATA_WIDTH  debug read data (no bypass)
- pending_cnt  out  ADDRESS_WIDTH+1  number of busy bits set

## Operation
- Register 0: reads always 0, rd_ready always 1, never written, never marked busy.
- Read i: if ra_i==0 -> 0; else if BYPASS && we && wa==ra_i -> wd; else stored value.
- rd_ready_i: 1 if ra_i==0; else !busy[ra_i], or 1 when BYPASS && we && wa==ra_i (and busy not re-set this cycle counts only for the current read).
- Write: on edge with we && wa!=0 && !rst, reg[wa] <= wd, busy[wa] <= 0.
- Issue: on edge with iss_en && iss_addr!=0 && !flush && !rst, busy[iss_addr] <= 1.
- Same address issued and written in one cycle: data written, busy ends set (new producer wins).
- flush: all busy bits cleared; a concurrent iss_en is dropped; a concurrent write still commits.
- Issue to an already-busy register: stays busy (no counting per register; single outstanding producer tracked).
- pending_cnt: registered popcount of busy, updated same edge as busy (reflects post-edge state, not combinational from busy).
- dbg_data: stored value of reg[dbg_addr], 0 for address 0, no forwarding.

## Timing
- Reads, rd_ready, dbg_data: combinational, zero latency.
- Write visible from stored array the cycle after we; visible same cycle only through bypass (BYPASS=1).
- Busy set by issue at edge N, first visible as rd_ready=0 in cycle N+1.
- rst high at an edge: all registers 0, all busy 0, pending_cnt 0 after that edge; iss_en/we ignored on that edge. rst mid-operation discards pending state without writing.
- After reset: rd=0, rd_ready=all 1, dbg_data=0, pending_cnt=0.
- pending_cnt max 2**ADDRESS_WIDTH-1 (x0 excluded); width AW+1 never wraps.

## Test plan
- Reset then write x5=0xDEADBEEF; next cycle ra0=5 -> rd0=0xDEADBEEF, rd_ready0=1; dbg_addr=5 -> same.
- Write x0=0x1234, read ra=0 -> rd=0, rd_ready=1; issue x0 -> pending_cnt stays 0.
- Issue x7; next cycle ra1=7 -> rd_ready1=0, pending_cnt=1; cycle with we, wa=7, wd=0x55 -> BYPASS=1: rd1=0x55, rd_ready1=1; BYPASS=0: rd1=old value, rd_ready1=0; following cycle ready=1, cnt=0.
- Same cycle iss x3 and write x3=0xAA -> reg x3=0xAA, busy[3]=1, pending_cnt=1.
- Issue x1,x2,x3 over 3 cycles (cnt=3), then flush with iss_en x4 and we x9=0x11 -> cnt=0, x4 not busy, x9=0x11.
- With regs and busy populated, assert rst one cycle -> all reads 0, all ready 1, cnt 0; write during rst cycle not stored.

Source files
------------

// File: rtl/reg_file_sb.sv
// Architectural register file with per-register busy scoreboard.
// Combinational reads with optional writeback bypass, one write port, issue/flush tracking.
module reg_file_sb #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_PORTS    = 2,
    parameter int unsigned BYPASS        = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0]   ra,
    output logic [READ_PORTS*DATA_WIDTH-1:0]      rd,
    output logic [READ_PORTS-1:0]                 rd_ready,
    input  logic                                  iss_en,
    input  logic [ADDRESS_WIDTH-1:0]              iss_addr,
    input  logic                                  we,
    input  logic [ADDRESS_WIDTH-1:0]              wa,
    input  logic [DATA_WIDTH-1:0]                 wd,
    input  logic                                  flush,
    input  logic [ADDRESS_WIDTH-1:0]              dbg_addr,
    output logic [DATA_WIDTH-1:0]                 dbg_data,
    output logic [ADDRESS_WIDTH:0]                pending_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int unsigned CW    = ADDRESS_WIDTH + 1;
    localparam bit          BYP   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_nxt;
    logic [CW-1:0]            cnt_nxt;
    logic                     wr_c;
    logic                     iss_c;
    logic [ADDRESS_WIDTH-1:0] rd_addr;

    assign wr_c  = we && (wa != '0);
    assign iss_c = iss_en && (iss_addr != '0) && !flush;

    // Next busy vector: writeback clears, a same-address issue re-sets it, flush wins over both.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        if (wr_c) begin
            busy_nxt[wa] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (iss_c) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr_c) begin
                regs[wa] <= wd;
            end
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    // Read ports: x0 hardwired, then optional forwarding of the in-flight writeback.
    always_comb begin
        rd       = '0;
        rd_ready = '0;
        rd_addr  = '0;
        for (int p = 0; p < int'(READ_PORTS); p++) begin
            rd_addr = ra[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if (rd_addr == '0) begin
                rd[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_ready[p]                    = 1'b1;
            end else if (BYP && wr_c && (wa == rd_addr)) begin
                rd[p*DATA_WIDTH +: DATA_WIDTH] = wd;
                rd_ready[p]                    = 1'b1;
            end else begin
                rd[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr];
                rd_ready[p]                    = !busy[rd_addr];
            end
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
